// File: rtl/i2s_adc_rx_if.sv
// Stereo frame bus from the I2S receiver to the sample path: {left, right} data,
// valid/ready handshake and a sticky overrun flag with its clear.
interface i2s_adc_rx_if #(
    parameter int WIDTH = 16
);
    logic [2*WIDTH-1:0] ADCDATA;
    logic               adc_valid;
    logic               adc_ready;
    logic               overrun;
    logic               overrun_clr;

    modport master (
        output ADCDATA,
        output adc_valid,
        output overrun,
        input  adc_ready,
        input  overrun_clr
    );

    modport slave (
        input  ADCDATA,
        input  adc_valid,
        input  overrun,
        output adc_ready,
        output overrun_clr
    );
endinterface

// File: rtl/i2s_adc_rx.sv
// Master-mode I2S ADC receiver: makes BCLK/LRCK from Clk, frame valid 1 Clk after last right-channel rise.
// Frames are never stalled: an unconsumed frame is overwritten and flagged via sticky overrun.
module i2s_adc_rx #(
    parameter int BCLK_DIV = 8,
    parameter int SLOT     = 32,
    parameter int WIDTH    = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Enable,
    input  logic          AUD_ADCDAT,
    output logic          AUD_BCLK,
    output logic          AUD_ADCLRCK,
    i2s_adc_rx_if.master  bus
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(2*SLOT);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV-1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2*SLOT-1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT);
    localparam logic [BW-1:0] WIDTH_B  = BW'(WIDTH);

    logic             sync1, sync2;
    logic [DW-1:0]    div;
    logic [BW-1:0]    bitcnt, bit_nxt, pos;
    logic             wrap, rise, fall, right_ch, cap;
    logic [WIDTH-1:0] left_sr, right_sr;
    logic             frame_done;

    assign wrap     = Enable && (div == DIV_LAST);
    assign rise     = wrap && !AUD_BCLK;
    assign fall     = wrap && AUD_BCLK;
    assign right_ch = (bitcnt >= SLOT_B);
    assign pos      = right_ch ? (bitcnt - SLOT_B) : bitcnt;
    assign bit_nxt  = (bitcnt == BIT_LAST) ? '0 : bitcnt + 1'b1;
    // Slot position 0 is the I2S one-bit delay after the LRCK edge; MSB lands at position 1.
    assign cap      = rise && (pos != '0) && (pos <= WIDTH_B);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= AUD_ADCDAT;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div         <= '0;
            bitcnt      <= '0;
            AUD_BCLK    <= 1'b0;
            AUD_ADCLRCK <= 1'b0;
        end else if (!Enable) begin
            div         <= '0;
            bitcnt      <= '0;
            AUD_BCLK    <= 1'b0;
            AUD_ADCLRCK <= 1'b0;
        end else begin
            div <= wrap ? '0 : div + 1'b1;
            if (wrap) begin
                AUD_BCLK <= !AUD_BCLK;
            end
            // LRCK follows the new bit count so it changes together with BCLK falling.
            if (fall) begin
                bitcnt      <= bit_nxt;
                AUD_ADCLRCK <= (bit_nxt >= SLOT_B);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            left_sr    <= '0;
            right_sr   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= cap && right_ch && (pos == WIDTH_B);
            if (!Enable) begin
                left_sr  <= '0;
                right_sr <= '0;
            end else if (cap) begin
                if (right_ch) begin
                    right_sr <= {right_sr[WIDTH-2:0], sync2};
                end else begin
                    left_sr  <= {left_sr[WIDTH-2:0], sync2};
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.ADCDATA   <= '0;
            bus.adc_valid <= 1'b0;
            bus.overrun   <= 1'b0;
        end else if (frame_done) begin
            bus.ADCDATA   <= {left_sr, right_sr};
            bus.adc_valid <= 1'b1;
            // A ready in the load cycle consumes the old frame, so only a stalled one overruns.
            if (bus.adc_valid && !bus.adc_ready) begin
                bus.overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                bus.overrun <= 1'b0;
            end
        end else begin
            if (bus.adc_valid && bus.adc_ready) begin
                bus.adc_valid <= 1'b0;
            end
            if (bus.overrun_clr) begin
                bus.overrun <= 1'b0;
            end
        end
    end
endmodule
